// File: rtl/gray_codec_stream.sv
// Streaming Gray<->binary converter with a registered output stage and one skid
// slot, so in_ready comes straight from a flop and full throughput is kept.
module gray_codec_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic             skid_valid;
    logic             skid_mode;
    logic [WIDTH-1:0] skid_data;

    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] conv_data;

    logic             out_valid_nxt;
    logic             out_mode_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic             skid_valid_nxt;
    logic             skid_mode_nxt;
    logic [WIDTH-1:0] skid_data_nxt;

    always_comb begin
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid & out_ready;
        conv_data = in_mode ? (in_data ^ (in_data >> 1)) : gray2bin(in_data);

        out_valid_nxt  = out_valid;
        out_mode_nxt   = out_mode;
        out_data_nxt   = out_data;
        skid_valid_nxt = skid_valid;
        skid_mode_nxt  = skid_mode;
        skid_data_nxt  = skid_data;

        // in_ready is low whenever SKID is full, so the first branch never sees in_xfer
        if (out_xfer && skid_valid) begin
            out_valid_nxt  = 1'b1;
            out_mode_nxt   = skid_mode;
            out_data_nxt   = skid_data;
            skid_valid_nxt = 1'b0;
        end else if (in_xfer && (!out_valid || out_xfer)) begin
            out_valid_nxt = 1'b1;
            out_mode_nxt  = in_mode;
            out_data_nxt  = conv_data;
        end else if (in_xfer) begin
            skid_valid_nxt = 1'b1;
            skid_mode_nxt  = in_mode;
            skid_data_nxt  = conv_data;
        end else if (out_xfer) begin
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_mode   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_mode  <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            out_valid  <= out_valid_nxt;
            out_mode   <= out_mode_nxt;
            out_data   <= out_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_mode  <= skid_mode_nxt;
            skid_data  <= skid_data_nxt;
            in_ready   <= ~skid_valid_nxt;
            if (out_xfer) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_codec_stream.sv
// Scoreboard bench for gray_codec_stream: WIDTH=4 instance through a queue,
// plus a WIDTH=8 instance checked directly.
module tb_gray_codec_stream;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [3:0]  in_data, out_data;
    logic [15:0] xfer_cnt;

    logic        v8_in_valid, v8_in_ready, v8_in_mode, v8_out_valid, v8_out_ready, v8_out_mode;
    logic [7:0]  v8_in_data, v8_out_data;
    logic [15:0] v8_xfer_cnt;

    int vecs = 0;
    int errs = 0;
    int acc_cnt = 0;
    int model_cnt = 0;
    logic [4:0] sb[$];

    gray_codec_stream #(.WIDTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .xfer_cnt(xfer_cnt)
    );

    gray_codec_stream #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_mode(v8_in_mode), .in_data(v8_in_data),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_mode(v8_out_mode),
        .out_data(v8_out_data), .xfer_cnt(v8_xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Gray->binary by searching for the index whose Gray code matches.
    function automatic int ref_conv(input int w, input int mode, input int d);
        if (mode != 0) return d ^ (d >> 1);
        for (int v = 0; v < (1 << w); v++) begin
            if ((v ^ (v >> 1)) == d) return v;
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        sb.delete();
        acc_cnt   = 0;
        model_cnt = 0;
        in_valid  = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Expected words enter the scoreboard when the DUT accepts them.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst && in_valid && in_ready) begin
            e = {in_mode, 4'(ref_conv(4, int'(in_mode), int'(in_data)))};
            sb.push_back(e);
            acc_cnt++;
        end
    end

    logic       stall = 1'b0;
    logic [4:0] stall_word;

    always @(negedge clk) begin
        logic [4:0] e;
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_stable", 32'({out_mode, out_data}), 32'(stall_word));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'({out_mode, out_data}), 32'h1f);
                    check("unexpected_output_q", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 32'(out_data), 32'(e[3:0]));
                    check("sb_mode", 32'(out_mode), 32'(e[4]));
                end
                model_cnt++;
            end
            stall      = out_valid && !out_ready;
            stall_word = {out_mode, out_data};
        end
    end

    initial begin
        int start_acc;
        int budget;
        rst = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
        v8_in_valid = 1'b0; v8_in_mode = 1'b0; v8_in_data = '0; v8_out_ready = 1'b1;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_mode", 32'(out_mode), 32'd0);
        check("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        check("first_edge_in_ready", 32'(in_ready), 32'd1);

        // All 16 Gray codes, mode 0, full rate
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_data = 4'(i ^ (i >> 1));
            cyc();
            check("stream_out_valid", 32'(out_valid), 32'd1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_index", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        cyc();
        check("xfer_cnt_16", 32'(xfer_cnt), 32'd16);
        check("drained_valid", 32'(out_valid), 32'd0);

        // Binary->Gray, then round trip of the encoded values back through mode 0
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_mode = 1'b1; in_data = 4'(i);
            cyc();
        end
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_data = 4'(i ^ (i >> 1));
            cyc();
            check("round_trip", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        cyc();
        check("xfer_cnt_model", 32'(xfer_cnt), 32'(model_cnt));

        // Backpressure: three offers, two accepted
        out_ready = 1'b0;
        start_acc = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 1'(i); in_data = 4'(5 + i);
            cyc();
        end
        check("bp_accepted", 32'(acc_cnt - start_acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        cyc();
        check("bp_stable_data", 32'(out_data), 32'(ref_conv(4, 0, 5)));
        out_ready = 1'b1;
        cyc();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_data", 32'(out_data), 32'(ref_conv(4, 1, 6)));
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        cyc();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Random traffic, 1000 words, counter starting from a fresh reset
        async_reset();
        budget = 20000;
        while (acc_cnt < 1000 && budget > 0) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_mode   = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            budget--;
        end
        check("random_accepted", 32'(acc_cnt), 32'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 100;
        while (sb.size() != 0 && budget > 0) begin
            cyc();
            budget--;
        end
        cyc();
        check("random_drained", 32'(sb.size()), 32'd0);
        check("random_xfer_cnt", 32'(xfer_cnt), 32'd1000);

        // Reset with OUT and SKID full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 1'b1; in_data = 4'(9 + i);
            cyc();
        end
        check("full_before_rst", 32'(in_ready), 32'd0);
        async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("no_stale_word", 32'(out_valid), 32'd0);
        end

        // WIDTH=8 instance
        v8_in_valid = 1'b1; v8_in_mode = 1'b0; v8_in_data = 8'h80;
        cyc();
        check("w8_g2b_80", 32'(v8_out_data), 32'hff);
        v8_in_mode = 1'b1; v8_in_data = 8'hff;
        cyc();
        check("w8_b2g_ff", 32'(v8_out_data), 32'h80);
        for (int i = 0; i < 8; i++) begin
            v8_in_mode = 1'($urandom_range(0, 1));
            v8_in_data = 8'($urandom_range(0, 255));
            cyc();
            check("w8_valid", 32'(v8_out_valid), 32'd1);
            check("w8_mode", 32'(v8_out_mode), 32'(v8_in_mode));
            check("w8_data", 32'(v8_out_data), 32'(ref_conv(8, int'(v8_in_mode), int'(v8_in_data))));
        end
        v8_in_valid = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/gray_codec_stream.md
GRAY_CODEC_STREAM -- requirements
Module: gray_codec_stream

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the code word width in bits; legal range is 2..32.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the transfer counter width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit, meaning an input word is offered.
REQ-006 The module SHALL have port in_ready, output, 1 bit, meaning the block can accept an input word.
REQ-007 The module SHALL have port in_mode, input, 1 bit, selecting the conversion: 0 = Gray->binary, 1 = binary->Gray.
REQ-008 The module SHALL have port in_data, input, WIDTH bits, the word to convert.
REQ-009 The module SHALL have port out_valid, output, 1 bit, meaning a converted word is presented.
REQ-010 The module SHALL have port out_ready, input, 1 bit, meaning the sink accepts the word.
REQ-011 The module SHALL have port out_mode, output, 1 bit, the in_mode value that travelled with the word.
REQ-012 The module SHALL have port out_data, output, WIDTH bits, the converted word.
REQ-013 The module SHALL have port xfer_cnt, output, CNT_W bits, counting completed output handshakes.

Function
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-015 Gray->binary SHALL be: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i from WIDTH-2 down to 0.
REQ-016 Binary->Gray SHALL be: g = b XOR (b >> 1), logical shift.
REQ-017 Conversion SHALL be applied to in_data before registering, so out_data is always fully converted and needs no further logic.
REQ-018 The datapath SHALL consist of an output register (OUT) and one skid register (SKID), each holding data, mode and a valid flag.
REQ-019 in_ready SHALL equal NOT SKID.valid, driven directly from a flop with no combinational path from out_ready.
REQ-020 On an input transfer, if OUT is empty or an output transfer occurs in the same cycle with SKID empty, the word SHALL load into OUT; otherwise it SHALL load into SKID.
REQ-021 On an output transfer with SKID valid, the SKID contents SHALL move to OUT and SKID SHALL become empty in the same cycle.
REQ-022 Latency from an input transfer to out_valid SHALL be exactly 1 cycle when OUT is empty or draining.
REQ-023 With out_ready held at 1 and in_valid held at 1, throughput SHALL be one word per cycle.
REQ-024 While out_valid is 1 and out_ready is 0, out_data and out_mode SHALL remain stable.
REQ-025 No accepted word SHALL be dropped, duplicated or reordered.
REQ-026 xfer_cnt SHALL increment by 1 on every output transfer and wrap from all-ones to 0.
REQ-027 in_mode SHALL be sampled per word, so consecutive words with different modes are each converted correctly.

Reset
REQ-028 While rst is 1, asynchronously: out_valid = 0, SKID.valid = 0, in_ready = 0, out_data = 0, out_mode = 0, xfer_cnt = 0.
REQ-029 On the first rising clk edge after rst deasserts, in_ready SHALL become 1.
REQ-030 Reset mid-operation SHALL discard any words held in OUT and SKID without producing an output transfer.

Verification
REQ-031 WIDTH=4, mode 0, out_ready=1, stream all 16 Gray codes -> out_data is the binary index each cycle (e.g. 1000->1111, 1101->1001, 0010->0011); xfer_cnt = 16.
REQ-032 WIDTH=4, mode 1, in_data 0..15 -> out_data is 0000,0001,0011,0010,0110,...,1000; a round trip through mode 1 then mode 0 returns the original value.
REQ-033 WIDTH=8, mode 0, in_data 8'h80 -> 8'hFF; mode 1, in_data 8'hFF -> 8'h80.
REQ-034 Backpressure: hold out_ready=0 and offer 3 words -> 2 are accepted, in_ready falls to 0, out_data stays stable; release out_ready -> both words leave in order on consecutive cycles and in_ready returns to 1.
REQ-035 Random in_valid/out_ready at 50% with mixed modes over 1000 words -> scoreboard matches exactly and xfer_cnt = 1000 mod 2^CNT_W.
REQ-036 Assert rst asynchronously between clock edges with OUT and SKID full -> out_valid and in_ready go to 0 immediately, xfer_cnt = 0, and no stale word appears after reset.
